mips32_issue_ctrl: RTL and testbench
====================================

Name: mips32_issue_ctrl

Overview:
- Sequencer that feeds R-type instructions into the single-cycle mips32 datapath's 32-bit instruction input, one instruction per clk.
- Buffers instructions from a loader in a small FIFO and controls issue with a start/stop state machine.
- Screens out unsupported encodings by replacing them with a NOP, and keeps issue and illegal-instruction statistics.

Parameters:
- DEPTH, 8, FIFO entries. Must be a power of 2 and at least 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  loader offers in_instr this cycle.
- in_instr  input  32  instruction word from the loader.
- in_ready  output  1  FIFO accepts a word this cycle.
- start  input  1  begin issuing (pulse).
- stop  input  1  request drain-and-halt (pulse).
- instruction  output  32  registered word driven to the datapath instruction input.
- issue_valid  output  1  instruction holds a real popped word this cycle.
- illegal  output  1  one-cycle flag: the word now on instruction replaced an illegal encoding.
- busy  output  1  state is RUN or DRAIN.
- done  output  1  one-cycle pulse when DRAIN completes.
- fifo_level  output  $clog2(DEPTH)+1  current number of FIFO entries.
- issued_count  output  CNT_W  number of words popped and issued.
- illegal_count  output  CNT_W  number of words replaced by NOP.

Behaviour:
- Reset values: FIFO empty, state IDLE, instruction = 32'h0000_0000 (NOP, sll $0,$0,0), all 1-bit outputs 0, all counters 0.
- Reset mid-operation flushes the FIFO and loses in-flight words.
- Handshake and push:
  - A push occurs when in_valid && in_ready.
  - in_ready = !full && state != DRAIN.
  - When full, in_ready = 0 even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full FIFO keeps fifo_level unchanged.
  - There is no bypass: a word pushed at edge N is issued no earlier than edge N+1.
- Pop: occurs when state is RUN or DRAIN and the FIFO is not empty. Only the head word is read; pointers wrap modulo DEPTH.
- Issue on the edge of a pop:
  - instruction <= head word if legal, else 0.
  - issue_valid <= 1.
  - illegal <= !legal.
  - issued_count increments.
  - illegal_count increments if the word was illegal.
- No pop on an edge: instruction <= 0, issue_valid <= 0, illegal <= 0.
- Legal encoding: opcode[31:26] == 0 and funct[5:0] is one of 20 (add), 21 (addu), 22 (sub), 23 (subu), 24 (and), 25 (or), 27 (nor), 2B (sltu), 00 (sll), 02 (srl), 03 (sra), all in hex. Any other encoding is illegal.
- Counters saturate at all-ones and never wrap.
- FSM:
  - IDLE: no pops. start -> RUN; stop is ignored.
  - RUN: pops every cycle the FIFO is not empty. stop -> DRAIN; start is ignored. When start and stop are high together, stop wins.
  - DRAIN: pushes blocked, pops continue. When the FIFO is empty at the start of a cycle -> IDLE and done <= 1 for that one cycle. An already-empty FIFO on entry therefore takes one cycle in DRAIN.
- busy is registered from the state: 1 in RUN and DRAIN.
- Latency: the pop decision is registered, so instruction changes one edge after start is sampled at the earliest (IDLE -> RUN at edge E, first issue at edge E+1).

Test Plan:
- Basic issue: reset, push 00221820 (add $3,$1,$2) and 00221822 (sub), start -> instruction shows 00221820 then 00221822 on consecutive cycles with issue_valid=1, then 0 with issue_valid=0; issued_count=2.
- Full FIFO: in IDLE, push DEPTH=8 words -> fifo_level=8, in_ready=0; a ninth in_valid is not accepted; start -> 8 issues in order, wrap-around correct, then a further 8 pushes and issues stay in order.
- Illegal screening: push 8C220000 (lw) and 0022182A (slt, unsupported funct) -> both issue as 00000000 with illegal=1; illegal_count=2, issued_count=2.
- Drain: RUN with 3 entries queued, stop pulse -> in_ready=0, 3 issues, done=1 for exactly one cycle, then state IDLE with busy=0.
- Edge cases: start and stop high together in RUN -> DRAIN; stop in IDLE -> stays IDLE with no done; push and pop in the same cycle at level 4 -> level stays 4.
- Reset mid-run: reset asserted with 5 entries queued -> next cycle fifo_level=0, instruction=0, counters=0, state IDLE.

Source files
------------

// File: rtl/mips32_issue_ctrl.sv
// Feeds R-type words from a small FIFO into the mips32 instruction input, one per clk,
// under start/stop control. Unsupported encodings are issued as NOP and counted.
module mips32_issue_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    input  logic                     start,
    input  logic                     stop,
    output logic [31:0]              instruction,
    output logic                     issue_valid,
    output logic                     illegal,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         issued_count,
    output logic [CNT_W-1:0]         illegal_count
);

    // state   | meaning
    // S_IDLE  | holding, no pops; start -> S_RUN
    // S_RUN   | popping whenever not empty; stop -> S_DRAIN (stop beats start)
    // S_DRAIN | pushes blocked, popping until empty, then S_IDLE with a done pulse

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic [31:0]     r_instruction;
    logic            r_issue_valid;
    logic            r_illegal;
    logic            r_busy;
    logic            r_done;
    logic [CNT_W-1:0] r_issued_count;
    logic [CNT_W-1:0] r_illegal_count;

    logic            w_full;
    logic            w_empty;
    logic            w_in_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_done_nxt;
    logic            w_busy_nxt;
    logic [31:0]     w_head;
    logic            w_head_legal;

    function automatic logic f_legal(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        if (w[31:26] == 6'h00) begin
            case (w[5:0])
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                6'h27, 6'h2B, 6'h00, 6'h02, 6'h03: ok = 1'b1;
                default:                          ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    assign w_full       = (r_level == FULL_LVL);
    assign w_empty      = (r_level == '0);
    assign w_push       = in_valid && w_in_ready;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_legal = f_legal(w_head);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)   w_state_nxt = S_RUN;
            S_RUN:   if (stop)    w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty) w_state_nxt = S_IDLE;
            default:              w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_in_ready = !w_full && (r_state != S_DRAIN);
        w_pop      = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !w_empty;
        w_done_nxt = (r_state == S_DRAIN) && w_empty;
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Storage carries no reset; only pointers and level define occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instruction   <= '0;
            r_issue_valid   <= 1'b0;
            r_illegal       <= 1'b0;
            r_issued_count  <= '0;
            r_illegal_count <= '0;
        end else begin
            r_instruction <= (w_pop && w_head_legal) ? w_head : 32'h0000_0000;
            r_issue_valid <= w_pop;
            r_illegal     <= w_pop && !w_head_legal;
            if (w_pop && (r_issued_count != '1)) begin
                r_issued_count <= r_issued_count + 1'b1;
            end
            if (w_pop && !w_head_legal && (r_illegal_count != '1)) begin
                r_illegal_count <= r_illegal_count + 1'b1;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign instruction   = r_instruction;
    assign issue_valid   = r_issue_valid;
    assign illegal       = r_illegal;
    assign busy          = r_busy;
    assign done          = r_done;
    assign fifo_level    = r_level;
    assign issued_count  = r_issued_count;
    assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_mips32_issue_ctrl.sv
// Scoreboard bench for mips32_issue_ctrl: expected issue words are queued at push time
// and a negedge monitor compares them against every issued word.
module tb_mips32_issue_ctrl;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [31:0]       in_instr;
    logic              in_ready;
    logic              start;
    logic              stop;
    logic [31:0]       instruction;
    logic              issue_valid;
    logic              illegal;
    logic              busy;
    logic              done;
    logic [3:0]        fifo_level;
    logic [CNT_W-1:0]  issued_count;
    logic [CNT_W-1:0]  illegal_count;

    typedef struct {
        logic [31:0] w;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    mips32_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .start         (start),
        .stop          (stop),
        .instruction   (instruction),
        .issue_valid   (issue_valid),
        .illegal       (illegal),
        .busy          (busy),
        .done          (done),
        .fifo_level    (fifo_level),
        .issued_count  (issued_count),
        .illegal_count (illegal_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every issued word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (issue_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", instruction, 32'hxxxx_xxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("issue_instr", instruction, e.w);
                chk("issue_illegal", {31'd0, illegal}, {31'd0, e.ill});
            end
        end else begin
            chk("idle_instr", instruction, 32'h0);
            chk("idle_illegal", {31'd0, illegal}, 32'h0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] ew, input logic eill);
        in_valid = 1'b1;
        in_instr = w;
        chk("push_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back('{ew, eill});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        int          done_cnt;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = 32'h0;
        start    = 1'b0;
        stop     = 1'b0;
        cycles(2);
        reset = 1'b0;

        chk("rst_instruction", instruction, 32'h0);
        chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_level", {28'd0, fifo_level}, 32'd0);
        chk("rst_issued", {16'd0, issued_count}, 32'd0);
        chk("rst_illegal_cnt", {16'd0, illegal_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic issue
        push(32'h0022_1820, 32'h0022_1820, 1'b0);
        push(32'h0022_1822, 32'h0022_1822, 1'b0);
        chk("basic_level", {28'd0, fifo_level}, 32'd2);
        chk("basic_idle_no_pop", {16'd0, issued_count}, 32'd0);
        pulse_start();
        chk("basic_busy", {31'd0, busy}, 32'd1);
        chk("basic_first_latency", {16'd0, issued_count}, 32'd0);
        cycles(1);
        chk("basic_first_issue", instruction, 32'h0022_1820);
        cycles(3);
        chk("basic_issued", {16'd0, issued_count}, 32'd2);
        chk("basic_after_valid", {31'd0, issue_valid}, 32'd0);
        pulse_stop();
        chk("drain_empty_busy", {31'd0, busy}, 32'd1);
        chk("drain_empty_ready", {31'd0, in_ready}, 32'd0);
        wait_done();

        // Full FIFO with pointer wrap (pointers start at 2)
        for (int i = 0; i < DEPTH; i++) begin
            w = {6'h00, 5'd1, 5'd2, 5'(i), 5'd0, 6'h21};
            push(w, w, 1'b0);
        end
        chk("full_level", {28'd0, fifo_level}, 32'd8);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_instr = 32'h0022_1820;
        cycles(1);
        in_valid = 1'b0;
        chk("full_ninth_rejected", {28'd0, fifo_level}, 32'd8);
        pulse_start();
        cycles(10);
        chk("full_level_empty", {28'd0, fifo_level}, 32'd0);
        chk("full_issued", {16'd0, issued_count}, 32'd10);
        push(32'h0022_1824, 32'h0022_1824, 1'b0);
        push(32'h0022_1825, 32'h0022_1825, 1'b0);
        push(32'h0022_1827, 32'h0022_1827, 1'b0);
        push(32'h0022_182B, 32'h0022_182B, 1'b0);
        push(32'h0002_1080, 32'h0002_1080, 1'b0);
        push(32'h0002_1082, 32'h0002_1082, 1'b0);
        push(32'h0002_1083, 32'h0002_1083, 1'b0);
        push(32'h0022_1823, 32'h0022_1823, 1'b0);
        cycles(3);
        chk("full2_issued", {16'd0, issued_count}, 32'd18);
        chk("full2_illegal_cnt", {16'd0, illegal_count}, 32'd0);
        pulse_stop();
        wait_done();

        // Illegal screening
        push(32'h8C22_0000, 32'h0, 1'b1);
        push(32'h0022_182A, 32'h0, 1'b1);
        pulse_start();
        cycles(4);
        chk("ill_illegal_cnt", {16'd0, illegal_count}, 32'd2);
        chk("ill_issued", {16'd0, issued_count}, 32'd20);
        pulse_stop();
        wait_done();

        // Drain with 3 entries
        push(32'h0043_2020, 32'h0043_2020, 1'b0);
        push(32'h0043_2022, 32'h0043_2022, 1'b0);
        push(32'h0043_2021, 32'h0043_2021, 1'b0);
        pulse_start();
        pulse_stop();
        chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("drain_done_once", done_cnt, 32'd1);
        chk("drain_busy_end", {31'd0, busy}, 32'd0);
        chk("drain_issued", {16'd0, issued_count}, 32'd23);

        // start and stop together in RUN -> DRAIN
        pulse_start();
        chk("both_run_busy", {31'd0, busy}, 32'd1);
        chk("both_run_ready", {31'd0, in_ready}, 32'd1);
        start = 1'b1;
        stop  = 1'b1;
        cycles(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("both_in_drain", {31'd0, in_ready}, 32'd0);
        wait_done();

        // stop in IDLE is ignored
        pulse_stop();
        chk("idle_stop_busy", {31'd0, busy}, 32'd0);
        chk("idle_stop_ready", {31'd0, in_ready}, 32'd1);
        cycles(1);
        chk("idle_stop_no_done", {31'd0, done}, 32'd0);

        // Simultaneous push and pop at level 4
        for (int i = 0; i < 5; i++) begin
            w = {6'h00, 5'd3, 5'd4, 5'(i + 8), 5'd0, 6'h20};
            push(w, w, 1'b0);
        end
        pulse_start();
        chk("pp_level5", {28'd0, fifo_level}, 32'd5);
        cycles(1);
        chk("pp_level4", {28'd0, fifo_level}, 32'd4);
        push(32'h0064_2822, 32'h0064_2822, 1'b0);
        chk("pp_level_hold", {28'd0, fifo_level}, 32'd4);
        pulse_stop();
        wait_done();
        chk("pp_issued", {16'd0, issued_count}, 32'd29);
        chk("pp_illegal_cnt", {16'd0, illegal_count}, 32'd2);

        // Reset mid-run with 5 queued
        for (int i = 0; i < 5; i++) begin
            w = {6'h00, 5'd5, 5'd6, 5'(i), 5'd0, 6'h25};
            push(w, w, 1'b0);
        end
        pulse_start();
        chk("mid_level5", {28'd0, fifo_level}, 32'd5);
        reset = 1'b1;
        sb.delete();
        cycles(1);
        chk("mid_level", {28'd0, fifo_level}, 32'd0);
        chk("mid_instruction", instruction, 32'h0);
        chk("mid_issued", {16'd0, issued_count}, 32'd0);
        chk("mid_illegal_cnt", {16'd0, illegal_count}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        cycles(3);
        chk("mid_stays_idle", {16'd0, issued_count}, 32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
